// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. It captures the decoded control bundle and the operands, and it
// injects NOP bubbles on stall or flush. It also keeps a saturating count of the bubbles.
module id_ex_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic                  i_bubble,
    input  logic                  i_valid,
    input  logic                  i_reg_dst,
    input  logic [1:0]            i_alu_src_a,
    input  logic                  i_alu_src_b,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic                  i_mem_to_reg,
    input  logic                  i_reg_write,
    input  logic [2:0]            i_branch_type,
    input  logic [DATA_W-1:0]     i_pc_plus_4,
    input  logic [DATA_W-1:0]     i_rs_data,
    input  logic [DATA_W-1:0]     i_rt_data,
    input  logic [DATA_W-1:0]     i_imm_ext,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rt,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [4:0]            i_shamt,
    input  logic [5:0]            i_funct,
    input  logic [5:0]            i_opcode,
    output logic                  o_valid,
    output logic                  o_reg_dst,
    output logic [1:0]            o_alu_src_a,
    output logic                  o_alu_src_b,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_to_reg,
    output logic                  o_reg_write,
    output logic [2:0]            o_branch_type,
    output logic [DATA_W-1:0]     o_pc_plus_4,
    output logic [DATA_W-1:0]     o_rs_data,
    output logic [DATA_W-1:0]     o_rt_data,
    output logic [DATA_W-1:0]     o_imm_ext,
    output logic [REG_ADDR_W-1:0] o_rs,
    output logic [REG_ADDR_W-1:0] o_rt,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [4:0]            o_shamt,
    output logic [5:0]            o_funct,
    output logic [5:0]            o_opcode,
    output logic [REG_ADDR_W-1:0] o_write_reg,
    output logic [CNT_W-1:0]      o_bubble_cnt
);

    logic                  squash;
    logic [REG_ADDR_W-1:0] write_reg_d;
    logic [CNT_W-1:0]      bubble_cnt_d;

    always_comb begin
        squash       = i_flush | i_bubble;
        write_reg_d  = i_reg_dst ? i_rd : i_rt;
        bubble_cnt_d = (o_bubble_cnt == {CNT_W{1'b1}}) ? o_bubble_cnt
                                                        : o_bubble_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_reg_dst     <= 1'b0;
            o_alu_src_a   <= '0;
            o_alu_src_b   <= 1'b0;
            o_mem_read    <= 1'b0;
            o_mem_write   <= 1'b0;
            o_mem_to_reg  <= 1'b0;
            o_reg_write   <= 1'b0;
            o_branch_type <= '0;
            o_pc_plus_4   <= '0;
            o_rs_data     <= '0;
            o_rt_data     <= '0;
            o_imm_ext     <= '0;
            o_rs          <= '0;
            o_rt          <= '0;
            o_rd          <= '0;
            o_shamt       <= '0;
            o_funct       <= '0;
            o_opcode      <= '0;
            o_write_reg   <= '0;
            o_bubble_cnt  <= '0;
        end else if (i_enable) begin
            if (squash) begin
                // Clear the indices too, so that EX forwarding never matches a bubble.
                o_valid       <= 1'b0;
                o_reg_dst     <= 1'b0;
                o_alu_src_a   <= '0;
                o_alu_src_b   <= 1'b0;
                o_mem_read    <= 1'b0;
                o_mem_write   <= 1'b0;
                o_mem_to_reg  <= 1'b0;
                o_reg_write   <= 1'b0;
                o_branch_type <= '0;
                o_pc_plus_4   <= '0;
                o_rs_data     <= '0;
                o_rt_data     <= '0;
                o_imm_ext     <= '0;
                o_rs          <= '0;
                o_rt          <= '0;
                o_rd          <= '0;
                o_shamt       <= '0;
                o_funct       <= '0;
                o_opcode      <= '0;
                o_write_reg   <= '0;
                o_bubble_cnt  <= bubble_cnt_d;
            end else begin
                o_valid       <= i_valid;
                o_reg_dst     <= i_reg_dst;
                o_alu_src_a   <= i_alu_src_a;
                o_alu_src_b   <= i_alu_src_b;
                o_mem_read    <= i_mem_read;
                o_mem_write   <= i_mem_write & i_valid;
                o_mem_to_reg  <= i_mem_to_reg;
                o_reg_write   <= i_reg_write & i_valid;
                o_branch_type <= i_branch_type;
                o_pc_plus_4   <= i_pc_plus_4;
                o_rs_data     <= i_rs_data;
                o_rt_data     <= i_rt_data;
                o_imm_ext     <= i_imm_ext;
                o_rs          <= i_rs;
                o_rt          <= i_rt;
                o_rd          <= i_rd;
                o_shamt       <= i_shamt;
                o_funct       <= i_funct;
                o_opcode      <= i_opcode;
                o_write_reg   <= write_reg_d;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomised bench for id_ex_reg. A behavioural model predicts every output, and directed
// cases with literal expectations pin the model down.
module tb_id_ex_reg;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic        reg_dst;
        logic [1:0]  alu_src_a;
        logic        alu_src_b;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [2:0]  branch_type;
        logic [31:0] pc_plus_4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [5:0]  opcode;
    } in_t;

    typedef struct packed {
        in_t              f;
        logic [4:0]       write_reg;
        logic [CNT_W-1:0] cnt;
    } out_t;

    logic clk, rst_n, enable, flush, bubble;
    in_t  din;
    out_t act, exp_q, hold_ref;

    logic             o_valid, o_reg_dst, o_alu_src_b, o_mem_read, o_mem_write;
    logic             o_mem_to_reg, o_reg_write;
    logic [1:0]       o_alu_src_a;
    logic [2:0]       o_branch_type;
    logic [31:0]      o_pc_plus_4, o_rs_data, o_rt_data, o_imm_ext;
    logic [4:0]       o_rs, o_rt, o_rd, o_shamt, o_write_reg;
    logic [5:0]       o_funct, o_opcode;
    logic [CNT_W-1:0] o_bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_flush(flush), .i_bubble(bubble),
        .i_valid(din.valid), .i_reg_dst(din.reg_dst), .i_alu_src_a(din.alu_src_a),
        .i_alu_src_b(din.alu_src_b), .i_mem_read(din.mem_read), .i_mem_write(din.mem_write),
        .i_mem_to_reg(din.mem_to_reg), .i_reg_write(din.reg_write),
        .i_branch_type(din.branch_type), .i_pc_plus_4(din.pc_plus_4),
        .i_rs_data(din.rs_data), .i_rt_data(din.rt_data), .i_imm_ext(din.imm_ext),
        .i_rs(din.rs), .i_rt(din.rt), .i_rd(din.rd), .i_shamt(din.shamt),
        .i_funct(din.funct), .i_opcode(din.opcode),
        .o_valid(o_valid), .o_reg_dst(o_reg_dst), .o_alu_src_a(o_alu_src_a),
        .o_alu_src_b(o_alu_src_b), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
        .o_branch_type(o_branch_type), .o_pc_plus_4(o_pc_plus_4), .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_shamt(o_shamt), .o_funct(o_funct), .o_opcode(o_opcode),
        .o_write_reg(o_write_reg), .o_bubble_cnt(o_bubble_cnt)
    );

    always_comb begin
        act = '0;
        act.f.valid       = o_valid;
        act.f.reg_dst     = o_reg_dst;
        act.f.alu_src_a   = o_alu_src_a;
        act.f.alu_src_b   = o_alu_src_b;
        act.f.mem_read    = o_mem_read;
        act.f.mem_write   = o_mem_write;
        act.f.mem_to_reg  = o_mem_to_reg;
        act.f.reg_write   = o_reg_write;
        act.f.branch_type = o_branch_type;
        act.f.pc_plus_4   = o_pc_plus_4;
        act.f.rs_data     = o_rs_data;
        act.f.rt_data     = o_rt_data;
        act.f.imm_ext     = o_imm_ext;
        act.f.rs          = o_rs;
        act.f.rt          = o_rt;
        act.f.rd          = o_rd;
        act.f.shamt       = o_shamt;
        act.f.funct       = o_funct;
        act.f.opcode      = o_opcode;
        act.write_reg     = o_write_reg;
        act.cnt           = o_bubble_cnt;
    end

    // This function gives the outputs that the next edge must produce from the current state and inputs.
    function automatic out_t model_next(out_t cur, logic en, logic fl, logic bu, in_t d);
        out_t n;
        int   c;
        n = cur;
        if (en) begin
            if (fl || bu) begin
                c = int'(cur.cnt) + 1;
                if (c > CNT_MAX) c = CNT_MAX;
                n = '0;
                n.cnt = c[CNT_W-1:0];
            end else begin
                n.f = d;
                if (!d.valid) begin
                    n.f.reg_write = 1'b0;
                    n.f.mem_write = 1'b0;
                end
                n.write_reg = d.reg_dst ? d.rd : d.rt;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= '0;
        else        exp_q <= model_next(exp_q, enable, flush, bubble, din);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            if (act !== exp_q) begin
                n_fail++;
                $display("FAIL model_compare t=%0t got=%h want=%h", $time, act, exp_q);
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_din();
        logic [223:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             $urandom()};
        din = in_t'(r[$bits(in_t)-1:0]);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int sat_seq [5];
        sat_seq = '{1, 2, 3, 3, 3};
        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; bubble = 1'b0; din = '0;
        cyc();
        rst_n = 1'b1;

        // Load nonzero outputs, then assert reset in the middle of a cycle.
        enable = 1'b1;
        din.valid = 1'b1; din.pc_plus_4 = 32'h1234; din.rt = 5'd4; din.reg_write = 1'b1;
        cyc();
        chk("pre_reset_pc", act.f.pc_plus_4, 32'h1234);
        #2 rst_n = 1'b0;
        #1 chk("async_clear", act, '0);
        @(negedge clk) rst_n = 1'b1;

        din = '0; din.valid = 1'b1; din.alu_src_b = 1'b1; din.reg_write = 1'b1;
        din.rt = 5'd5; din.rd = 5'd9; din.imm_ext = 32'h0000_FFFF; din.opcode = 6'h08;
        cyc();
        chk("addi_write_reg", act.write_reg, 5);
        chk("addi_imm", act.f.imm_ext, 32'h0000_FFFF);
        chk("addi_reg_write", act.f.reg_write, 1);
        chk("addi_valid", act.f.valid, 1);

        din = '0; din.valid = 1'b1; din.mem_read = 1'b1; din.mem_to_reg = 1'b1;
        din.reg_write = 1'b1; din.rt = 5'd3; din.opcode = 6'h23;
        bubble = 1'b1;
        cyc();
        chk("lw_bubble_mem_read", act.f.mem_read, 0);
        chk("lw_bubble_reg_write", act.f.reg_write, 0);
        chk("lw_bubble_valid", act.f.valid, 0);
        chk("lw_bubble_write_reg", act.write_reg, 0);
        chk("lw_bubble_cnt", act.cnt, 1);
        bubble = 1'b0;
        cyc();
        chk("lw_capture_mem_read", act.f.mem_read, 1);
        chk("lw_capture_write_reg", act.write_reg, 3);

        din = '0; din.valid = 1'b1; din.branch_type = 3'b110; din.reg_dst = 1'b1;
        din.rd = 5'd31; din.reg_write = 1'b1; din.opcode = 6'h03;
        flush = 1'b1; bubble = 1'b1;
        cyc();
        chk("jal_flush_branch", act.f.branch_type, 0);
        chk("jal_flush_reg_write", act.f.reg_write, 0);
        chk("jal_flush_cnt", act.cnt, 2);

        flush = 1'b0; bubble = 1'b0;
        rand_din();
        cyc();
        hold_ref = exp_q;
        enable = 1'b0; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = '0; din.valid = 1'b1; din.mem_write = 1'b1; din.rt = 5'(i + 10);
            din.opcode = 6'h2b;
            cyc();
            chk("hold_outputs", act, hold_ref);
            chk("hold_cnt", act.cnt, 2);
        end

        enable = 1'b1; flush = 1'b0;
        din = '0; din.reg_write = 1'b1; din.mem_write = 1'b1; din.rd = 5'd7; din.rt = 5'd2;
        din.reg_dst = 1'b1;
        cyc();
        chk("invalid_valid", act.f.valid, 0);
        chk("invalid_reg_write", act.f.reg_write, 0);
        chk("invalid_mem_write", act.f.mem_write, 0);
        chk("invalid_write_reg", act.write_reg, 7);

        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        bubble = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_din();
            cyc();
            chk("saturation_cnt", act.cnt, sat_seq[i]);
        end
        bubble = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            rand_din();
            enable = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 7) == 0);
            bubble = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #3 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the ID stage (control decoder plus register file) and the EX stage.
- Captures the decoded control bundle and the operand/data fields each enabled cycle.
- Inserts bubbles on load-use stall and on branch/jump flush.
- Holds state when the debug unit freezes the pipeline.
- Precomputes the write-back register index for forwarding.
- Keeps a saturating count of injected bubbles for the debug unit.

Parameters:
- DATA_W, 32, width of data and PC fields
- REG_ADDR_W, 5, width of register indices
- CNT_W, 16, width of bubble counter

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  pipeline advance enable (debug step); 0 = hold everything
- i_flush  in  1  squash ID instruction (taken branch/jump resolved)
- i_bubble  in  1  load-use stall: inject NOP into EX
- i_valid  in  1  ID holds a real instruction
- i_reg_dst  in  1  0 = rt, 1 = rd destination
- i_alu_src_a  in  2  ALU A select (reg / PC+4 / shamt)
- i_alu_src_b  in  1  ALU B select (reg / imm)
- i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write  in  1 each  memory/WB controls
- i_branch_type  in  3  branch kind; 3'b000 = none
- i_pc_plus_4, i_rs_data, i_rt_data, i_imm_ext  in  DATA_W each  data fields
- i_rs, i_rt, i_rd  in  REG_ADDR_W each  register indices (rd already forced to 31 for JAL/JALR)
- i_shamt  in  5  shift amount
- i_funct  in  6  function field
- i_opcode  in  6  opcode
- o_<field>  out  same widths  registered copy of every i_<field> above, excluding i_enable/i_flush/i_bubble
- o_valid  out  1  registered i_valid
- o_write_reg  out  REG_ADDR_W  registered destination index
- o_bubble_cnt  out  CNT_W  saturating bubble counter

Behaviour:
- Reset: asynchronous on i_rst_n = 0. All outputs go to 0, including o_branch_type = NONE, o_valid = 0 and o_bubble_cnt = 0. Release is synchronous to the next i_clk edge.
- Per-edge priority: reset > hold (i_enable = 0) > flush > bubble > capture.
- Hold (i_enable = 0): every output keeps its value. i_flush and i_bubble are ignored. The counter does not change.
- Flush or bubble (i_enable = 1, i_flush | i_bubble):
  - Load the NOP bundle: all control outputs 0, o_branch_type = 0, o_valid = 0, o_write_reg = 0.
  - Data and index outputs go to 0, so the EX forwarding compare never hits.
  - o_bubble_cnt increments by 1 and saturates at 2^CNT_W-1.
  - Flush and bubble in the same cycle count as one bubble.
- Capture (i_enable = 1, neither asserted):
  - Every o_<field> takes its i_<field>.
  - o_write_reg = i_reg_dst ? i_rd : i_rt.
  - If i_valid = 0, still capture, but force o_reg_write = 0 and o_mem_write = 0 so no architectural side effect occurs.
- Latency: exactly 1 cycle from ID inputs to outputs. There is no combinational path from inputs to outputs.
- Counter behaviour at saturation: stays at max. It does not wrap.
- No internal state apart from the output registers and the counter.
- Reset asserted mid-hold: outputs clear immediately, without waiting for a clock edge.

Test Plan:
- Reset and capture:
  - Stimulus: assert i_rst_n = 0 mid-cycle with outputs nonzero; release; then one enabled capture of ADDI (reg_dst = 0, alu_src_b = 1, reg_write = 1, rt = 5, rd = 9, imm = 0x0000FFFF).
  - Required response: outputs clear asynchronously; the next edge gives o_write_reg = 5, o_imm_ext = 0x0000FFFF, o_reg_write = 1, o_valid = 1.
- Bubble on load-use:
  - Stimulus: LW (mem_read = 1, rt = 3) presented with i_bubble = 1 at edge N.
  - Required response: after N, o_mem_read = 0, o_reg_write = 0, o_valid = 0, o_write_reg = 0, o_bubble_cnt = 1. A capture at N+1 with i_bubble = 0 gives o_mem_read = 1, o_write_reg = 3.
- Flush over JAL:
  - Stimulus: JAL (branch_type = JAL, rd = 31, reg_write = 1) with i_flush = 1 and i_bubble = 1 together.
  - Required response: o_branch_type = 0, o_reg_write = 0, counter +1 (not +2).
- Hold priority:
  - Stimulus: i_enable = 0 with i_flush = 1 and new SW inputs for 3 cycles.
  - Required response: outputs and o_bubble_cnt unchanged from the prior value.
- Invalid capture:
  - Stimulus: i_valid = 0 with i_reg_write = 1, i_mem_write = 1, rd = 7, reg_dst = 1.
  - Required response: o_valid = 0, o_reg_write = 0, o_mem_write = 0, o_write_reg = 7.
- Saturation (bench overrides CNT_W = 2):
  - Stimulus: 5 consecutive bubbles.
  - Required response: o_bubble_cnt sequence is 1, 2, 3, 3, 3.
